msg_buffer: RTL



---
 rtl/msg_buffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/msg_buffer.sv
// -----------------------------------------------------------------------------
// msg_buffer
// One router message buffer. A bit-serial message (16-bit address header, MSB
// first, then DATA_W payload bits, MSB first) is deserialised into a single
// shift register. While held, the buffer advertises occupancy, address and an
// aging priority to the max-priority selector. On grant the whole message is
// shifted back out bit-serially in the order it arrived and the buffer empties.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   : message carries one trailing even-parity bit; a mismatch pulses
//               err for one cycle and drops the message.
//   undefined : no parity bit; err is tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_bit is meaningful this cycle
//   in_bit    in   serial message bit in
//   in_ready  out  buffer accepts in_bit this cycle (combinational)
//   grant     in   single-cycle select pulse from the selector
//   occupied  out  message held and eligible for selection
//   addr      out  captured address, bit 0 = first bit received
//   pri       out  current aging priority
//   out_valid out  out_bit is meaningful
//   out_bit   out  serial message bit out
//   err       out  one-cycle parity failure pulse
// -----------------------------------------------------------------------------
module msg_buffer #(
    parameter int DATA_W     = 32,
    parameter int AGE_PERIOD = 16,
    parameter int BASE_PRI   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    input  logic        grant,
    output logic        occupied,
    output logic [0:15] addr,
    output logic [0:2]  pri,
    output logic        out_valid,
    output logic        out_bit,
    output logic        err
);

    localparam int MSG_W = 16 + DATA_W;
`ifdef PARITY_CHECK_EN
    localparam int MSG_L = MSG_W + 1;
`else
    localparam int MSG_L = MSG_W;
`endif
    localparam int CNT_W = $clog2(MSG_L + 1);
    localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_L);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(MSG_W);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);
    localparam logic [2:0]       PRI_BASE = 3'(BASE_PRI);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_HOLD,
        S_SEND
    } state_t;

    state_t             r_state;
    logic [MSG_W-1:0]   r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [AGE_W-1:0]   r_age;
    logic               r_occupied;
    logic [15:0]        r_addr;
    logic [2:0]         r_pri;
    logic               r_out_valid;
    logic               r_out_bit;
    logic               r_err;

    logic               w_take;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last_in;
    logic [MSG_W-1:0]   w_sr_cap;
    logic               w_par_bad;

    // Accept bits only while empty or loading; HOLD/SEND back-pressure.
    assign in_ready  = (r_state == S_EMPTY) || (r_state == S_LOAD);
    assign w_take    = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last_in = (w_cnt_inc == CNT_LAST);

    // Only message bits enter the shift register; a trailing parity bit
    // (count already at MSG_W) leaves it untouched.
    assign w_sr_cap  = (r_cnt < CNT_DATA) ? {r_sr[MSG_W-2:0], in_bit} : r_sr;

`ifdef PARITY_CHECK_EN
    logic r_par;
    logic w_par_acc;
    // Running XOR restarts with the first bit of each message.
    assign w_par_acc = ((r_state == S_EMPTY) ? 1'b0 : r_par) ^ in_bit;
    // At the parity bit, r_par holds the XOR of all message bits.
    assign w_par_bad = (in_bit != r_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par <= 1'b0;
        else if (w_take)
            r_par <= w_par_acc;
    end
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_age       <= '0;
            r_occupied  <= 1'b0;
            r_addr      <= '0;
            r_pri       <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_EMPTY, S_LOAD: begin
                    if (in_valid) begin
                        r_sr    <= w_sr_cap;
                        r_cnt   <= w_cnt_inc;
                        r_state <= S_LOAD;
                        if (w_last_in) begin
                            r_cnt <= '0;
                            if (w_par_bad) begin
                                // Corrupt message is dropped outright.
                                r_err   <= 1'b1;
                                r_state <= S_EMPTY;
                            end else begin
                                r_state    <= S_HOLD;
                                r_occupied <= 1'b1;
                                r_addr     <= w_sr_cap[MSG_W-1 -: 16];
                                r_pri      <= PRI_BASE;
                                r_age      <= '0;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (grant) begin
                        // Grant beats a same-cycle age tick; the buffer drops
                        // out of selection immediately and starts sending.
                        r_state     <= S_SEND;
                        r_occupied  <= 1'b0;
                        r_addr      <= '0;
                        r_pri       <= '0;
                        r_age       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_bit   <= r_sr[MSG_W-1];
                        r_sr        <= {r_sr[MSG_W-2:0], 1'b0};
                        r_cnt       <= CNT_W'(1);
                    end else if (r_age == AGE_LAST) begin
                        r_age <= '0;
                        if (r_pri != 3'd7)
                            r_pri <= r_pri + 3'd1;
                    end else begin
                        r_age <= r_age + 1'b1;
                    end
                end

                S_SEND: begin
                    // r_cnt counts bits already presented on out_bit.
                    if (r_cnt == CNT_DATA) begin
                        r_out_valid <= 1'b0;
                        r_out_bit   <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_EMPTY;
                    end else begin
                        r_out_bit <= r_sr[MSG_W-1];
                        r_sr      <= {r_sr[MSG_W-2:0], 1'b0};
                        r_cnt     <= w_cnt_inc;
                    end
                end

                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign occupied  = r_occupied;
    assign addr      = r_addr;
    assign pri       = r_pri;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign err       = r_err;

endmodule
